// File: rtl/mini_src_mem_pkg.sv
// Shared types and constants for the main-memory port arbiter.
// Grant encoding, FSM state encoding and default bus widths live here so the
// interface, the arbiter and its sub-module agree on them.
package mini_src_mem_pkg;

    // Legacy-compatible state codes; the enum below reuses them.
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_ACK    = 2'd2;

    typedef enum logic [1:0] {
        IDLE   = ST_IDLE,
        ACCESS = ST_ACCESS,
        ACK    = ST_ACK
    } arb_state_t;

    // Grant owner encoding.
    localparam logic OWNER_CPU = 1'b0;
    localparam logic OWNER_DBG = 1'b1;

    // Default bus widths: 512-word memory of 32-bit words.
    localparam int DEF_ADDR_W = 9;
    localparam int DEF_DATA_W = 32;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the two requester handshakes, the memory port and the status
// outputs of the main-memory arbiter.
// slave  : the arbiter's view (takes requests, drives acks and the memory port)
// master : the environment's view (requesters plus the memory itself)
interface mem_port_arbiter_if
    import mini_src_mem_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) ();

    // CPU control unit requester
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_ack;
    logic [DATA_W-1:0] cpu_rdata;

    // Debug / program-loader requester
    logic              dbg_req;
    logic              dbg_we;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_wdata;
    logic              dbg_ack;
    logic [DATA_W-1:0] dbg_rdata;

    // Single-ported main memory
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    // Status
    logic              busy;
    logic              owner;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_ack, cpu_rdata,
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
        output dbg_ack, dbg_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata,
        output busy, owner
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_ack, cpu_rdata,
        output dbg_req, dbg_we, dbg_addr, dbg_wdata,
        input  dbg_ack, dbg_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata,
        input  busy, owner
    );

endinterface

// File: rtl/mem_wait_timer.sv
// Loadable 4-bit down-counter with a zero flag. Times the ACCESS phase:
// loaded with the wait-state count on a grant, counted down once per ACCESS
// cycle; the access ends in the cycle where the flag is set.
module mem_wait_timer
    import mini_src_mem_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       dec,
    output logic       zero
);

    logic [3:0] wait_cnt_reg;

    // Load has priority over decrement; the counter parks at zero.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wait_cnt_reg <= 4'd0;
        end else if (load) begin
            wait_cnt_reg <= load_val;
        end else if (dec && (wait_cnt_reg != 4'd0)) begin
            wait_cnt_reg <= wait_cnt_reg - 4'd1;
        end
    end

    assign zero = (wait_cnt_reg == 4'd0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single-ported main memory between the CPU control unit
// (requester 0) and the debug/program-loader port (requester 1).
// Each access runs IDLE -> ACCESS (WAIT_CYCLES+1 cycles) -> ACK -> IDLE.
// Contention is resolved by fixed CPU priority with a starvation bound: after
// STARVE_LIMIT consecutive CPU grants made while dbg_req was pending, the
// debug port is forced through.
// Build option: define MEM_ARB_ROUND_ROBIN_EN to replace the starvation bound
// with round-robin between the two requesters on simultaneous requests.
module mem_port_arbiter
    import mini_src_mem_pkg::*;
#(
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int DATA_W       = DEF_DATA_W,
    parameter int WAIT_CYCLES  = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic               clock,
    input  logic               reset,
    mem_port_arbiter_if.slave  bus
);

    arb_state_t        state_reg;
    arb_state_t        state_next;

    logic              grant;
    logic              grant_owner;
    logic              grant_we;
    logic [ADDR_W-1:0] grant_addr;
    logic [DATA_W-1:0] grant_wdata;
    logic              pick_dbg;
    logic              wait_zero;

    logic              owner_reg;
    logic              we_reg;
    logic              busy_reg;
    logic              mem_en_reg;
    logic              mem_we_reg;
    logic [ADDR_W-1:0] mem_addr_reg;
    logic [DATA_W-1:0] mem_wdata_reg;

    // Per-requester outputs, index 0 = CPU, 1 = DBG.
    logic [1:0]        ack_reg;
    logic [DATA_W-1:0] rdata_reg [2];

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // On contention, hand the port to whoever did not have it last.
    assign pick_dbg = (owner_reg == OWNER_CPU);
`else
    logic [3:0] starve_cnt_reg;

    // On contention the CPU wins until the debug port has waited long enough.
    assign pick_dbg = (starve_cnt_reg == 4'(STARVE_LIMIT));

    // Count CPU grants that overtook a pending debug request.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            starve_cnt_reg <= 4'd0;
        end else if (state_reg == IDLE) begin
            if (!bus.dbg_req) begin
                starve_cnt_reg <= 4'd0;
            end else if (grant && (grant_owner == OWNER_DBG)) begin
                starve_cnt_reg <= 4'd0;
            end else if (grant && (starve_cnt_reg < 4'(STARVE_LIMIT))) begin
                starve_cnt_reg <= starve_cnt_reg + 4'd1;
            end
        end
    end
`endif

    // Next-state logic and grant selection (grants are only made in IDLE).
    always_comb begin
        state_next  = state_reg;
        grant       = 1'b0;
        grant_owner = OWNER_CPU;
        case (state_reg)
            IDLE: begin
                if (bus.cpu_req || bus.dbg_req) begin
                    grant      = 1'b1;
                    state_next = ACCESS;
                    if (bus.cpu_req && bus.dbg_req) begin
                        grant_owner = pick_dbg ? OWNER_DBG : OWNER_CPU;
                    end else begin
                        grant_owner = bus.dbg_req ? OWNER_DBG : OWNER_CPU;
                    end
                end
            end
            ACCESS: begin
                if (wait_zero) begin
                    state_next = ACK;
                end
            end
            ACK: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Request fields of whichever requester is being granted.
    always_comb begin
        grant_we    = (grant_owner == OWNER_DBG) ? bus.dbg_we    : bus.cpu_we;
        grant_addr  = (grant_owner == OWNER_DBG) ? bus.dbg_addr  : bus.cpu_addr;
        grant_wdata = (grant_owner == OWNER_DBG) ? bus.dbg_wdata : bus.cpu_wdata;
    end

    // Times the WAIT_CYCLES+1 cycles of ACCESS.
    mem_wait_timer u_wait_timer (
        .clock    (clock),
        .reset    (reset),
        .load     (grant),
        .load_val (4'(WAIT_CYCLES)),
        .dec      (state_reg == ACCESS),
        .zero     (wait_zero)
    );

    // State register plus registered status and memory-enable outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg  <= IDLE;
            busy_reg   <= 1'b0;
            mem_en_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            busy_reg   <= (state_next != IDLE);
            mem_en_reg <= (state_next == ACCESS);
        end
    end

    // Latch the granted request; later requester input changes are ignored.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            owner_reg     <= OWNER_CPU;
            we_reg        <= 1'b0;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
        end else if (grant) begin
            owner_reg     <= grant_owner;
            we_reg        <= grant_we;
            mem_we_reg    <= grant_we;
            mem_addr_reg  <= grant_addr;
            mem_wdata_reg <= grant_wdata;
        end else if (state_next != ACCESS) begin
            mem_we_reg    <= 1'b0;
        end
    end

    // Per-requester ack pulse and read-data capture, only for the owner.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            // Ack is raised for the single ACK cycle of this requester's access.
            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    ack_reg[gi] <= 1'b0;
                end else begin
                    ack_reg[gi] <= (state_next == ACK) && (owner_reg == 1'(gi));
                end
            end

            // Read data is captured in the last ACCESS cycle and held until
            // this requester's next read completes.
            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    rdata_reg[gi] <= '0;
                end else if ((state_reg == ACCESS) && wait_zero && !we_reg
                             && (owner_reg == 1'(gi))) begin
                    rdata_reg[gi] <= bus.mem_rdata;
                end
            end
        end
    endgenerate

    assign bus.cpu_ack   = ack_reg[0];
    assign bus.dbg_ack   = ack_reg[1];
    assign bus.cpu_rdata = rdata_reg[0];
    assign bus.dbg_rdata = rdata_reg[1];
    assign bus.mem_en    = mem_en_reg;
    assign bus.mem_we    = mem_we_reg;
    assign bus.mem_addr  = mem_addr_reg;
    assign bus.mem_wdata = mem_wdata_reg;
    assign bus.busy      = busy_reg;
    assign bus.owner     = owner_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter. Two instances share one memory
// model: u_dut_a with two wait states, u_dut_b with none; sel_b chooses which
// one receives requests and is observed. Expected values come from a shadow
// copy of memory updated per transaction and from the arbitration rules.
module tb_mem_port_arbiter;
    import mini_src_mem_pkg::*;

    localparam int AW     = 9;
    localparam int DW     = 32;
    localparam int WAIT_A = 2;
    localparam int WAIT_B = 0;
    localparam int LIMIT  = 4;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) if_a ();
    mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) if_b ();

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(WAIT_A), .STARVE_LIMIT(LIMIT))
        u_dut_a (.clock(clock), .reset(reset), .bus(if_a));
    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(WAIT_B), .STARVE_LIMIT(LIMIT))
        u_dut_b (.clock(clock), .reset(reset), .bus(if_b));

    logic          sel_b = 1'b0;
    logic          cpu_req = 1'b0, cpu_we = 1'b0, dbg_req = 1'b0, dbg_we = 1'b0;
    logic [AW-1:0] cpu_addr = '0, dbg_addr = '0;
    logic [DW-1:0] cpu_wdata = '0, dbg_wdata = '0;

    assign if_a.cpu_req   = cpu_req & ~sel_b;
    assign if_a.dbg_req   = dbg_req & ~sel_b;
    assign if_b.cpu_req   = cpu_req & sel_b;
    assign if_b.dbg_req   = dbg_req & sel_b;
    assign if_a.cpu_we    = cpu_we;    assign if_b.cpu_we    = cpu_we;
    assign if_a.cpu_addr  = cpu_addr;  assign if_b.cpu_addr  = cpu_addr;
    assign if_a.cpu_wdata = cpu_wdata; assign if_b.cpu_wdata = cpu_wdata;
    assign if_a.dbg_we    = dbg_we;    assign if_b.dbg_we    = dbg_we;
    assign if_a.dbg_addr  = dbg_addr;  assign if_b.dbg_addr  = dbg_addr;
    assign if_a.dbg_wdata = dbg_wdata; assign if_b.dbg_wdata = dbg_wdata;

    // Observed outputs of the selected instance
    logic          o_cpu_ack, o_dbg_ack, o_mem_en, o_mem_we, o_busy, o_owner;
    logic [AW-1:0] o_mem_addr;
    logic [DW-1:0] o_mem_wdata, o_cpu_rdata, o_dbg_rdata;
    assign o_cpu_ack   = sel_b ? if_b.cpu_ack   : if_a.cpu_ack;
    assign o_dbg_ack   = sel_b ? if_b.dbg_ack   : if_a.dbg_ack;
    assign o_mem_en    = sel_b ? if_b.mem_en    : if_a.mem_en;
    assign o_mem_we    = sel_b ? if_b.mem_we    : if_a.mem_we;
    assign o_busy      = sel_b ? if_b.busy      : if_a.busy;
    assign o_owner     = sel_b ? if_b.owner     : if_a.owner;
    assign o_mem_addr  = sel_b ? if_b.mem_addr  : if_a.mem_addr;
    assign o_mem_wdata = sel_b ? if_b.mem_wdata : if_a.mem_wdata;
    assign o_cpu_rdata = sel_b ? if_b.cpu_rdata : if_a.cpu_rdata;
    assign o_dbg_rdata = sel_b ? if_b.dbg_rdata : if_a.dbg_rdata;

    // Memory: combinational read, write on a clock edge with en & we.
    logic [DW-1:0] mem_arr [0:511];
    logic [DW-1:0] shadow  [0:511];
    logic          pl_en = 1'b0;
    logic [AW-1:0] pl_addr = '0;
    logic [DW-1:0] pl_data = '0;

    assign if_a.mem_rdata = mem_arr[if_a.mem_addr];
    assign if_b.mem_rdata = mem_arr[if_b.mem_addr];

    always @(posedge clock) begin
        if (pl_en) mem_arr[pl_addr] <= pl_data;
        else if (o_mem_en && o_mem_we) mem_arr[o_mem_addr] <= o_mem_wdata;
    end

    logic last_owner = OWNER_CPU;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic who, input logic req, input logic we,
                         input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
        if (who == OWNER_DBG) begin
            dbg_req = req; dbg_we = we; dbg_addr = addr; dbg_wdata = wdata;
        end else begin
            cpu_req = req; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
        end
    endtask

    // One uncontended access: latency, memory-port activity, ack exclusivity,
    // owner and read data are all checked against the rules and the shadow.
    task automatic do_access(input logic who, input logic we, input logic [AW-1:0] addr,
                             input logic [DW-1:0] wdata, input int wc, output int ack_cyc);
        int k = 0, en_n = 0, we_n = 0, bad = 0, other = 0;
        bit got = 0;
        @(negedge clock);
        check("idle_busy", o_busy, 0);
        drive(who, 1'b1, we, addr, wdata);
        while (!got && k < 40) begin
            @(negedge clock);
            k++;
            if (o_mem_en) begin
                en_n++;
                if (o_mem_we) we_n++;
                if (o_mem_addr !== addr || (we && o_mem_wdata !== wdata)) bad++;
            end
            if (k == 1) begin
                // Request fields change after the grant; the access must not care.
                if (who == OWNER_DBG) begin dbg_addr = AW'($urandom); dbg_wdata = $urandom; end
                else begin cpu_addr = AW'($urandom); cpu_wdata = $urandom; end
            end
            if ((who == OWNER_DBG) ? o_cpu_ack : o_dbg_ack) other++;
            if ((who == OWNER_DBG) ? o_dbg_ack : o_cpu_ack) got = 1;
        end
        ack_cyc = cyc;
        check("ack_latency", k, wc + 2);
        check("mem_en_cycles", en_n, wc + 1);
        check("mem_we_cycles", we_n, we ? wc + 1 : 0);
        check("mem_bus_fields", bad, 0);
        check("non_owner_ack", other, 0);
        check("owner", o_owner, who);
        check("busy_in_ack", o_busy, 1);
        if (we) shadow[addr] = wdata;
        else check(who ? "dbg_rdata" : "cpu_rdata", who ? o_dbg_rdata : o_cpu_rdata, shadow[addr]);
        drive(who, 1'b0, 1'b0, '0, '0);
        last_owner = who;
        $display("[TB] t=%0d %s %s addr=0x%h data=0x%h ack_cycle=%0d", cyc,
                 who ? "DBG" : "CPU", we ? "WR" : "RD", addr,
                 we ? wdata : (who ? o_dbg_rdata : o_cpu_rdata), ack_cyc);
    endtask

    initial begin
        int t0, t1, t2, t3, n, guard, prev, starve, acks;
        logic exp_own;
        logic [AW-1:0] cpu_a, dbg_a, r_addr;
        logic [DW-1:0] r_data;
        logic r_who, r_we;

        // Preload memory and the shadow while reset is held
        for (int i = 0; i < 512; i++) begin
            @(negedge clock);
            pl_en = 1'b1; pl_addr = AW'(i);
            pl_data = (i == 16) ? 32'hDEADBEEF : $urandom;
            shadow[i] = pl_data;
        end
        @(negedge clock);
        pl_en = 1'b0;
        @(negedge clock);
        reset = 1'b0;

        // Reset state
        @(negedge clock);
        check("rst_cpu_ack", o_cpu_ack, 0);
        check("rst_dbg_ack", o_dbg_ack, 0);
        check("rst_cpu_rdata", o_cpu_rdata, 0);
        check("rst_dbg_rdata", o_dbg_rdata, 0);
        check("rst_mem_en", o_mem_en, 0);
        check("rst_mem_we", o_mem_we, 0);
        check("rst_mem_addr", o_mem_addr, 0);
        check("rst_mem_wdata", o_mem_wdata, 0);
        check("rst_busy", o_busy, 0);
        check("rst_owner", o_owner, 0);

        // First read after reset, then a debug write read back by the CPU
        do_access(OWNER_CPU, 1'b0, 9'h010, '0, WAIT_A, t0);
        check("first_read_value", o_cpu_rdata, 32'hDEADBEEF);
        do_access(OWNER_DBG, 1'b1, 9'h1FF, 32'h12345678, WAIT_A, t0);
        do_access(OWNER_CPU, 1'b0, 9'h1FF, '0, WAIT_A, t0);
        check("dbg_write_readback", o_cpu_rdata, 32'h12345678);

        // Both requests held continuously
        cpu_a = 9'h020; dbg_a = 9'h030;
        @(negedge clock);
        drive(OWNER_CPU, 1'b1, 1'b0, cpu_a, '0);
        drive(OWNER_DBG, 1'b1, 1'b0, dbg_a, '0);
        starve = 0; n = 0; guard = 0; prev = -1;
        while (n < 12 && guard < 200) begin
            @(negedge clock);
            guard++;
            if (o_cpu_ack || o_dbg_ack) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
                exp_own = ~last_owner;
`else
                if (starve == LIMIT) begin exp_own = OWNER_DBG; starve = 0; end
                else begin exp_own = OWNER_CPU; starve = (starve < LIMIT) ? starve + 1 : LIMIT; end
`endif
                check("arb_ack_pair", {o_cpu_ack, o_dbg_ack}, exp_own ? 2'b01 : 2'b10);
                check("arb_owner", o_owner, exp_own);
                check("arb_rdata", exp_own ? o_dbg_rdata : o_cpu_rdata,
                      shadow[exp_own ? dbg_a : cpu_a]);
                if (prev >= 0) check("arb_spacing", cyc - prev, WAIT_A + 3);
                $display("[TB] t=%0d contention grant %0d -> %s", cyc, n, o_dbg_ack ? "DBG" : "CPU");
                prev = cyc; last_owner = exp_own; n++;
            end
        end
        check("arb_grant_count", n, 12);
        drive(OWNER_CPU, 1'b0, 1'b0, '0, '0);
        drive(OWNER_DBG, 1'b0, 1'b0, '0, '0);

        // Randomized single-requester traffic
        for (int i = 0; i < 16; i++) begin
            r_who  = 1'($urandom_range(0, 1));
            r_we   = 1'($urandom_range(0, 1));
            r_addr = AW'($urandom_range(0, 15));
            r_data = $urandom;
            repeat ($urandom_range(0, 3)) @(negedge clock);
            do_access(r_who, r_we, r_addr, r_data, WAIT_A, t0);
        end

        // Reset in the second ACCESS cycle of a CPU write
        @(negedge clock);
        drive(OWNER_CPU, 1'b1, 1'b1, 9'h0AA, 32'hCAFEF00D);
        @(negedge clock);
        @(negedge clock);
        check("rst_mid_en_before", o_mem_en, 1);
        reset = 1'b1;
        #1;
        check("rst_mid_mem_en", o_mem_en, 0);
        check("rst_mid_mem_we", o_mem_we, 0);
        check("rst_mid_busy", o_busy, 0);
        check("rst_mid_cpu_ack", o_cpu_ack, 0);
        check("rst_mid_cpu_rdata", o_cpu_rdata, 0);
        shadow[9'h0AA] = 32'hCAFEF00D;  // one write edge happened before reset
        last_owner = OWNER_CPU;
        drive(OWNER_CPU, 1'b0, 1'b0, '0, '0);
        @(negedge clock);
        reset = 1'b0;
        acks = 0;
        repeat (6) begin
            @(negedge clock);
            if (o_cpu_ack || o_dbg_ack) acks++;
        end
        check("rst_mid_no_ack", acks, 0);
        do_access(OWNER_CPU, 1'b0, 9'h0AA, '0, WAIT_A, t0);

        // Zero wait states: write/read of 0x005 and back-to-back reads
        @(negedge clock);
        sel_b = 1'b1;
        do_access(OWNER_CPU, 1'b1, 9'h005, 32'hA5A5_0005, WAIT_B, t0);
        do_access(OWNER_CPU, 1'b0, 9'h005, '0, WAIT_B, t1);
        check("w0_write_readback", o_cpu_rdata, 32'hA5A5_0005);
        do_access(OWNER_CPU, 1'b0, 9'h010, '0, WAIT_B, t2);
        do_access(OWNER_CPU, 1'b0, 9'h1FF, '0, WAIT_B, t3);
        check("w0_ack_spacing_1", t2 - t1, 3);
        check("w0_ack_spacing_2", t3 - t2, 3);
        do_access(OWNER_DBG, 1'b0, 9'h005, '0, WAIT_B, t0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
